// File: rtl/score_flash_ctrl_if.sv
// Signal bundle between game logic / VGA timing and the score-flash sequencer.
// The sequencer sits on the slave side.
interface score_flash_ctrl_if;
  logic [10:0] col_addr_sig;
  logic [10:0] row_addr_sig;
  logic        levelup_req;
  logic        pause;
  logic        sel_special;
  logic        busy;
  logic        done;
  logic [1:0]  pending;

  modport master (
    output col_addr_sig, row_addr_sig, levelup_req, pause,
    input  sel_special, busy, done, pending
  );

  modport slave (
    input  col_addr_sig, row_addr_sig, levelup_req, pause,
    output sel_special, busy, done, pending
  );
endinterface

// File: rtl/score_flash_ctrl.sv
// Score-panel overlay sequencer: turns level-up requests into a frame-aligned
// blink schedule selecting the special or normal score image.
module score_flash_ctrl #(
  parameter int unsigned FRAME_DIV   = 15,
  parameter int unsigned PHASES      = 8,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned PEND_MAX    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  score_flash_ctrl_if.slave bus
);

  // frame_cnt doubles as the HOLD frame counter, so size it for the larger use
  localparam int unsigned CNT_MAX = (FRAME_DIV > HOLD_FRAMES) ? FRAME_DIV : HOLD_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PH_W    = $clog2(PHASES);

  typedef enum logic [1:0] {IDLE, ARM, FLASH, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PH_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       pending_q, pending_d;
  logic             at0, at0_q, tick_q, tick_d, eff_tick;
  logic             pend_inc, pend_dec;

  // Only the first cycle at the scan origin produces a tick
  assign at0      = (bus.col_addr_sig == '0) && (bus.row_addr_sig == '0);
  assign tick_d   = at0 && !at0_q;
  assign eff_tick = tick_q && !bus.pause;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    pend_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = 1'b0;
        if (pending_q != '0) begin
          state_d  = ARM;
          pend_dec = 1'b1;
        end else if (bus.levelup_req) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (eff_tick) begin
          state_d     = FLASH;
          frame_cnt_d = '0;
          phase_cnt_d = '0;
          sel_d       = 1'b1;
        end
      end
      FLASH: begin
        if (eff_tick) begin
          if (frame_cnt_q == CNT_W'(FRAME_DIV - 1)) begin
            frame_cnt_d = '0;
            if (phase_cnt_q == PH_W'(PHASES - 1)) begin
              state_d = HOLD;
              sel_d   = 1'b0;
            end else begin
              phase_cnt_d = phase_cnt_q + 1'b1;
              sel_d       = !sel_q;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (eff_tick) begin
          if (frame_cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
            frame_cnt_d = '0;
            done_d      = 1'b1;
            if (pending_q != '0) begin
              state_d  = ARM;
              pend_dec = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A request IDLE cannot take directly (busy, or already draining the queue) is queued
    pend_inc  = bus.levelup_req && ((state_q != IDLE) || (pending_q != '0));
    pending_d = pending_q;
    if (pend_inc && !pend_dec && (pending_q < 2'(PEND_MAX))) begin
      pending_d = pending_q + 2'd1;
    end else if (pend_dec && !pend_inc) begin
      pending_d = pending_q - 2'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      phase_cnt_q <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pending_q   <= '0;
      at0_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      at0_q       <= at0;
      tick_q      <= tick_d;
    end
  end

  assign bus.sel_special = sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pending     = pending_q;

endmodule
